// File: rtl/addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_sched
//  Description : Round-robin scheduler sharing one registered 16-bit add/sub
//                datapath between two requesters, with per-op response
//                timeout and a valid/ready result return path.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_sched #(
    parameter int DW  = 16,
    parameter int TMO = 15      // 1..255, wait-state cycles before timeout
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_sub,
    input  logic [DW-1:0] r0_a,
    input  logic [DW-1:0] r0_b,
    output logic          r0_rvalid,
    input  logic          r0_rready,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_rflag,
    output logic          r0_rerr,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_sub,
    input  logic [DW-1:0] r1_a,
    input  logic [DW-1:0] r1_b,
    output logic          r1_rvalid,
    input  logic          r1_rready,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_rflag,
    output logic          r1_rerr,
    output logic          dp_valid,
    output logic          dp_sub,
    output logic [DW-1:0] dp_a,
    output logic [DW-1:0] dp_b,
    input  logic          dp_done,
    input  logic [DW-1:0] dp_result,
    input  logic          dp_carry,
    output logic          busy,
    output logic          err,
    input  logic          err_clr
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;
    // Counter is 8 bits wide, which bounds TMO to 255.
    localparam logic [7:0] c_tmo   = TMO[7:0];

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic          r_owner;     // requester that owns the in-flight op
    logic          r_last;      // last granted requester; 1 so r0 wins first tie
    logic          r_sub;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_rdata;
    logic          r_rflag;
    logic          r_rerr;
    logic          r_err;
    logic [7:0]    r_cnt;

    logic w_gnt0;
    logic w_gnt1;
    logic w_accept;
    logic w_done;
    logic w_tmo;
    logic w_take;
    logic w_idle;
    logic w_resp;

    // Round-robin: a sole requester wins; on a tie the one not granted last wins.
    assign w_gnt0   = r0_valid & (~r1_valid |  r_last);
    assign w_gnt1   = r1_valid & (~r0_valid | ~r_last);
    assign w_accept = (r_state == c_idle) & (w_gnt0 | w_gnt1);
    // A datapath result in the timeout cycle takes priority over the timeout.
    assign w_done   = (r_state == c_wait) & dp_done;
    assign w_tmo    = (r_state == c_wait) & ~dp_done & (r_cnt == c_tmo);
    assign w_take   = (r_state == c_resp) & (r_owner ? r1_rready : r0_rready);

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one op in flight; no new grant until the result is taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_next = c_issue;
            c_issue: w_next = c_wait;
            c_wait:  if (w_done || w_tmo) w_next = c_resp;
            c_resp:  if (w_take) w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    // Outputs: grants only in IDLE, result only to the owner.
    always_comb begin
        w_idle    = (r_state == c_idle) & ~wb_rst_i;
        w_resp    = (r_state == c_resp);
        r0_ready  = w_idle & w_gnt0;
        r1_ready  = w_idle & w_gnt1;
        dp_valid  = (r_state == c_issue);
        busy      = (r_state != c_idle);
        r0_rvalid = w_resp & ~r_owner;
        r1_rvalid = w_resp &  r_owner;
        r0_rdata  = r0_rvalid ? r_rdata : '0;
        r1_rdata  = r1_rvalid ? r_rdata : '0;
        r0_rflag  = r0_rvalid & r_rflag;
        r1_rflag  = r1_rvalid & r_rflag;
        r0_rerr   = r0_rvalid & r_rerr;
        r1_rerr   = r1_rvalid & r_rerr;
        dp_sub    = r_sub;
        dp_a      = r_a;
        dp_b      = r_b;
        err       = r_err;
    end

    // Command latch, timeout counter and result capture.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_sub   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= 8'd0;
            r_rdata <= '0;
            r_rflag <= 1'b0;
            r_rerr  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner <= w_gnt1;
                r_last  <= w_gnt1;
                r_sub   <= w_gnt1 ? r1_sub : r0_sub;
                r_a     <= w_gnt1 ? r1_a   : r0_a;
                r_b     <= w_gnt1 ? r1_b   : r0_b;
            end
            if (r_state == c_issue) begin
                r_cnt <= 8'd0;
            end else if ((r_state == c_wait) && !dp_done && (r_cnt != c_tmo)) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_done) begin
                r_rdata <= dp_result;
                r_rflag <= dp_carry;
                r_rerr  <= 1'b0;
            end else if (w_tmo) begin
                r_rdata <= '1;
                r_rflag <= 1'b0;
                r_rerr  <= 1'b1;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_addsub_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_sched
//  Description : Self-checking bench for addsub_sched: transaction-level
//                reference model, per-cycle compare, datapath emulator and
//                directed scenarios with hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_sched;

    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          r0_valid, r0_ready, r0_sub, r0_rvalid, r0_rready, r0_rflag, r0_rerr;
    logic [DW-1:0] r0_a, r0_b, r0_rdata;
    logic          r1_valid, r1_ready, r1_sub, r1_rvalid, r1_rready, r1_rflag, r1_rerr;
    logic [DW-1:0] r1_a, r1_b, r1_rdata;
    logic          dp_valid, dp_sub;
    logic [DW-1:0] dp_a, dp_b;
    logic          dp_done   = 1'b0;
    logic [DW-1:0] dp_result = '0;
    logic          dp_carry  = 1'b0;
    logic          busy, err, err_clr;

    addsub_sched #(.DW(DW), .TMO(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_sub(r0_sub), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_rdata(r0_rdata),
        .r0_rflag(r0_rflag), .r0_rerr(r0_rerr),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_sub(r1_sub), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_rdata(r1_rdata),
        .r1_rflag(r1_rflag), .r1_rerr(r1_rerr),
        .dp_valid(dp_valid), .dp_sub(dp_sub), .dp_a(dp_a), .dp_b(dp_b),
        .dp_done(dp_done), .dp_result(dp_result), .dp_carry(dp_carry),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- datapath emulator: answers dp_lat cycles after issue
    int          dp_lat  = 1;
    int          dp_cnt  = 0;
    bit          dp_mute = 1'b0;
    logic [15:0] e_a, e_b;
    logic        e_s;
    logic [16:0] e_r;

    always @(negedge wb_clk_i) begin
        if (dp_valid) begin
            e_a = dp_a; e_b = dp_b; e_s = dp_sub; dp_cnt = dp_lat;
        end
    end

    always @(posedge wb_clk_i) begin
        #1;
        dp_done = 1'b0;
        if (dp_cnt > 0) begin
            dp_cnt--;
            if (dp_cnt == 0 && !dp_mute) begin
                e_r       = e_s ? ({1'b0, e_a} - {1'b0, e_b}) : ({1'b0, e_a} + {1'b0, e_b});
                dp_result = e_r[15:0];
                dp_carry  = e_r[16];
                dp_done   = 1'b1;
            end
        end
    end

    // ---------------- transaction-level reference model
    logic        m_busy, m_strobe, m_waiting, m_resp, m_owner, m_last, m_err;
    logic [15:0] m_a, m_b, m_data;
    logic        m_sub, m_flag, m_rerr;
    logic [16:0] m_sum;
    int          m_waited;

    always @(posedge wb_clk_i or posedge wb_rst_i) begin : model
        logic g0, g1;
        if (wb_rst_i) begin
            m_busy = 0; m_strobe = 0; m_waiting = 0; m_resp = 0;
            m_owner = 0; m_last = 1; m_err = 0; m_waited = 0;
            m_a = 0; m_b = 0; m_sub = 0; m_data = 0; m_flag = 0; m_rerr = 0;
        end else begin
            if (m_waiting && !dp_done && m_waited == TMO) m_err = 1;
            else if (err_clr) m_err = 0;
            if (!m_busy) begin
                g0 = r0_valid && (!r1_valid || m_last);
                g1 = r1_valid && (!r0_valid || !m_last);
                if (g0 || g1) begin
                    m_owner = g1; m_last = g1;
                    m_a   = g1 ? r1_a   : r0_a;
                    m_b   = g1 ? r1_b   : r0_b;
                    m_sub = g1 ? r1_sub : r0_sub;
                    m_sum = m_sub ? ({1'b0, m_a} - {1'b0, m_b}) : ({1'b0, m_a} + {1'b0, m_b});
                    m_data = m_sum[15:0]; m_flag = m_sum[16]; m_rerr = 0;
                    m_busy = 1; m_strobe = 1;
                end
            end else if (m_strobe) begin
                m_strobe = 0; m_waiting = 1; m_waited = 0;
            end else if (m_waiting) begin
                if (dp_done) begin
                    m_waiting = 0; m_resp = 1;
                end else if (m_waited == TMO) begin
                    m_waiting = 0; m_resp = 1;
                    m_data = 16'hFFFF; m_flag = 0; m_rerr = 1;
                end else begin
                    m_waited++;
                end
            end else if (m_resp && (m_owner ? r1_rready : r0_rready)) begin
                m_resp = 0; m_busy = 0;
            end
        end
    end

    // ---------------- per-cycle compare against the model
    bit cmp_en = 1'b0;

    always @(negedge wb_clk_i) begin : cmp
        logic e0, e1;
        if (cmp_en) begin
            if (wb_rst_i) begin
                chk("rst_ready", {r0_ready, r1_ready}, 0);
                chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 0);
                chk("rst_dp_valid", dp_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", err, 0);
            end else begin
                e0 = !m_busy && r0_valid && (!r1_valid || m_last);
                e1 = !m_busy && r1_valid && (!r0_valid || !m_last);
                chk("r0_ready", r0_ready, e0);
                chk("r1_ready", r1_ready, e1);
                chk("dp_valid", dp_valid, m_strobe);
                chk("busy", busy, m_busy);
                chk("err", err, m_err);
                chk("r0_rvalid", r0_rvalid, m_resp && !m_owner);
                chk("r1_rvalid", r1_rvalid, m_resp && m_owner);
                if (m_busy) begin
                    chk("dp_a", dp_a, m_a);
                    chk("dp_b", dp_b, m_b);
                    chk("dp_sub", dp_sub, m_sub);
                end
                if (m_resp && !m_owner) begin
                    chk("r0_rdata", r0_rdata, m_data);
                    chk("r0_rflag", r0_rflag, m_flag);
                    chk("r0_rerr", r0_rerr, m_rerr);
                end
                if (m_resp && m_owner) begin
                    chk("r1_rdata", r1_rdata, m_data);
                    chk("r1_rflag", r1_rflag, m_flag);
                    chk("r1_rerr", r1_rerr, m_rerr);
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive at negedge+1)
    task automatic step();
        @(negedge wb_clk_i);
        #1;
    endtask

    task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic s, output int t_acc);
        bit got = 1'b0;
        if (n == 0) begin r0_valid = 1; r0_a = a; r0_b = b; r0_sub = s; end
        else        begin r1_valid = 1; r1_a = a; r1_b = b; r1_sub = s; end
        for (int k = 0; k < 100 && !got; k++) begin
            #1;
            got = (n == 0) ? r0_ready : r1_ready;
            step();
        end
        chk("accept_seen", got, 1);
        t_acc = cyc;
        if (n == 0) r0_valid = 0; else r1_valid = 0;
    endtask

    task automatic run_op(input int n, input logic [15:0] a, input logic [15:0] b,
                          input logic s, output int lat, output int nb,
                          output logic [15:0] d, output logic f, output logic e,
                          output logic other);
        int t0;
        bit seen = 1'b0;
        issue(n, a, b, s, t0);
        nb = 0; lat = -1; d = 0; f = 0; e = 0; other = 0;
        for (int k = 0; k < 60; k++) begin
            if (busy) nb++;
            if ((n == 0) ? r1_rvalid : r0_rvalid) other = 1;
            if (!seen && ((n == 0) ? r0_rvalid : r1_rvalid)) begin
                seen = 1; lat = cyc - t0;
                d = (n == 0) ? r0_rdata : r1_rdata;
                f = (n == 0) ? r0_rflag : r1_rflag;
                e = (n == 0) ? r0_rerr  : r1_rerr;
            end
            if (seen && !busy) break;
            step();
        end
        chk("rvalid_seen", seen, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int          lat, nb, t0, t1, owners[4], tacc[4], nrdy;
        logic [15:0] d;
        logic        f, e, o, stable;
        bit          seen;

        wb_rst_i = 1; err_clr = 0;
        r0_valid = 0; r0_sub = 0; r0_a = 0; r0_b = 0; r0_rready = 1;
        r1_valid = 0; r1_sub = 0; r1_a = 0; r1_b = 0; r1_rready = 1;
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);
        chk("reset_dp_a", dp_a, 0);
        cmp_en   = 1;
        wb_rst_i = 0;
        step();

        // Single add on r0
        run_op(0, 16'h0003, 16'h0005, 0, lat, nb, d, f, e, o);
        chk("add_lat", lat, 2);
        chk("add_busy_cycles", nb, 3);
        chk("add_data", d, 16'h0008);
        chk("add_flag", f, 0);
        chk("add_rerr", e, 0);

        // Subtract with borrow on r1
        run_op(1, 16'h0002, 16'h0005, 1, lat, nb, d, f, e, o);
        chk("sub_data", d, 16'hFFFD);
        chk("sub_flag", f, 1);
        chk("sub_r0_quiet", o, 0);

        // Round-robin with both requesters valid continuously
        r0_valid = 1; r0_a = 16'h1000; r0_b = 16'h0001; r0_sub = 0;
        r1_valid = 1; r1_a = 16'h2000; r1_b = 16'h0002; r1_sub = 1;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int j = 0; j < 20 && !seen; j++) begin
                #1;
                if (r0_ready || r1_ready) begin seen = 1; owners[k] = r1_ready ? 1 : 0; end
                step();
            end
            chk("rr_accept", seen, 1);
            tacc[k] = cyc;
            if (owners[k] == 0) r0_a = r0_a + 16'h0011; else r1_a = r1_a + 16'h0022;
        end
        r0_valid = 0; r1_valid = 0;
        chk("rr_grant0", owners[0], 0);
        chk("rr_grant1", owners[1], 1);
        chk("rr_grant2", owners[2], 0);
        chk("rr_grant3", owners[3], 1);
        for (int k = 1; k < 4; k++) chk("rr_spacing", tacc[k] - tacc[k-1], 4);
        repeat (5) step();

        // Timeout
        dp_mute = 1;
        run_op(0, 16'h1234, 16'h1111, 0, lat, nb, d, f, e, o);
        chk("tmo_lat", lat, TMO + 2);
        chk("tmo_data", d, 16'hFFFF);
        chk("tmo_flag", f, 0);
        chk("tmo_rerr", e, 1);
        chk("tmo_err_set", err, 1);
        err_clr = 1;
        step();
        chk("err_cleared", err, 0);
        err_clr = 0;

        // Timeout together with err_clr: set wins
        issue(0, 16'h0101, 16'h0202, 0, t0);
        err_clr = 1;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (r0_rvalid) seen = 1; else step();
        end
        chk("tmo2_seen", seen, 1);
        chk("tmo2_err_wins", err, 1);
        err_clr = 0;
        repeat (3) step();
        chk("tmo2_err_sticky", err, 1);
        dp_mute = 0;

        // Back-pressure: r0 holds its result, r1 waits
        r0_rready = 0;
        issue(0, 16'hABCD, 16'h1234, 1, t0);
        r1_valid = 1; r1_a = 16'h0707; r1_b = 16'h0101; r1_sub = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (r0_rvalid) seen = 1; else step();
        end
        chk("bp_seen", seen, 1);
        d = r0_rdata;
        chk("bp_data", d, 16'h9999);
        stable = 1; nrdy = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!r0_rvalid || r0_rdata !== d || r0_rerr !== 1'b0) stable = 0;
            if (r1_ready) nrdy++;
        end
        chk("bp_stable", stable, 1);
        chk("bp_r1_held_off", nrdy, 0);
        r0_rready = 1;
        t1 = cyc;
        issue(1, 16'h0707, 16'h0101, 0, t1);
        chk("bp_r1_after_handshake", t1 - t0 > 12, 1);
        repeat (5) step();

        // Asynchronous reset mid-WAIT
        dp_lat = 20;
        issue(0, 16'h0F0F, 16'h0101, 0, t0);
        step();
        r0_valid = 1;
        #2;
        wb_rst_i = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_err", err, 0);
        chk("arst_r0_ready", r0_ready, 0);
        chk("arst_dp_a", dp_a, 0);
        step();
        r0_valid = 0;
        step();
        wb_rst_i = 0;
        repeat (25) step();
        chk("late_done_ignored", busy, 0);
        dp_lat = 1;
        r0_valid = 1; r0_a = 16'h0050; r0_b = 16'h0005; r0_sub = 1;
        r1_valid = 1; r1_a = 16'h0060; r1_b = 16'h0006; r1_sub = 0;
        #1;
        chk("tie_after_reset_r0", r0_ready, 1);
        chk("tie_after_reset_r1", r1_ready, 0);
        step();
        r0_valid = 0;
        repeat (8) step();
        r1_valid = 0;
        repeat (6) step();

        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_sched.md
Name: addsub_sched

Overview:
- Scheduler that shares one registered 16-bit add/sub datapath between two requesters.
- Requester 0 is the wishbone-side command path; requester 1 is the logic-analyzer-side command path.
- Arbitration is round-robin; each accepted command is sequenced through the datapath, supervised by a response timeout, and its result is returned to the owning requester with a valid/ready handshake.
- Sits between the user-project front end and the add/sub datapath instance.

Parameters:
- DW, 16, operand and result width
- TMO, 15, maximum cycles in WAIT before timeout (1..255)

Ports:
- wb_clk_i  in  1  single clock; rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- rN_valid  in  1  requester N (N=0,1) command valid
- rN_ready  out  1  requester N command accepted this cycle
- rN_sub  in  1  1=a-b, 0=a+b
- rN_a  in  DW  operand a
- rN_b  in  DW  operand b
- rN_rvalid  out  1  result valid to requester N
- rN_rready  in  1  requester N takes result
- rN_rdata  out  DW  result
- rN_rflag  out  1  carry (add) / borrow (sub) from datapath
- rN_rerr  out  1  result produced by timeout, not by the datapath
- dp_valid  out  1  one-cycle issue strobe to datapath
- dp_sub  out  1  operation select, held from ISSUE until RESP
- dp_a  out  DW  operand a, held from ISSUE until RESP
- dp_b  out  DW  operand b, held from ISSUE until RESP
- dp_done  in  1  datapath result strobe
- dp_result  in  DW  datapath result
- dp_carry  in  1  datapath carry/borrow
- busy  out  1  state != IDLE
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

Behaviour:
- FSM states are IDLE, ISSUE, WAIT, RESP. Reset enters IDLE.
- Reset values: all outputs 0; last_grant=1 so requester 0 wins the first tie.
- IDLE:
  - Grant goes to the sole valid requester.
  - If both are valid, grant goes to the requester not equal to last_grant.
  - rN_ready = (state==IDLE) & grantN, a combinational one-cycle pulse.
  - On that edge: latch sub/a/b and owner, set last_grant=owner, go to ISSUE.
- ISSUE: dp_valid=1 for exactly one cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On dp_done: capture dp_result and dp_carry, rerr=0, go to RESP.
  - Otherwise the counter increments each cycle.
  - When counter==TMO with no dp_done: rdata=all ones, rflag=0, rerr=1, set err, go to RESP.
  - dp_done in the same cycle as the timeout wins; no error is raised.
- RESP:
  - Owner's rvalid=1 and rdata/rflag/rerr are held stable.
  - On owner's rready: go to IDLE.
  - The non-owner's rvalid stays 0.
  - Stalling rready holds RESP indefinitely; no new grants are made.
- dp_done while in IDLE, ISSUE or RESP is ignored.
- The datapath must not be re-issued before RESP completes: at most one op in flight.
- Latency with a 1-cycle datapath:
  - accept at edge T, dp_valid in cycle T+1, dp_done in cycle T+2, rvalid from T+3.
  - Minimum accept-to-accept spacing is 4 cycles with rready held high.
- The block performs no arithmetic; widths are passed through unchanged.
- err: set by a timeout; cleared by err_clr. Set wins over a simultaneous err_clr.
- rN_valid deasserted before acceptance has no effect; a request is never lost once accepted.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs 0, the in-flight op discarded, and last_grant=1. A late dp_done after reset is ignored.

Test Plan:
- Single add: r0 a=0x0003, b=0x0005, sub=0; dp returns 0x0008 carry 0 one cycle after dp_valid -> r0_rvalid at T+3, rdata=0x0008, rflag=0, rerr=0; busy high for 3 cycles.
- Subtract with borrow: r1 a=0x0002, b=0x0005, sub=1; dp returns 0xFFFD carry 1 -> r1_rdata=0xFFFD, r1_rflag=1; r0_rvalid stays 0.
- Round-robin: both valid continuously, 4 ops -> grant order r0, r1, r0, r1; each dp_a matches its owner's operand.
- Timeout: dp_done held 0 -> exactly TMO+1 cycles in WAIT, then rdata=0xFFFF, rerr=1, err=1. err_clr pulse -> err=0. Simultaneous timeout and err_clr -> err=1.
- Back-pressure: rready low for 10 cycles -> rvalid and data stable; r1_valid=1 meanwhile gets no ready until after the handshake.
- Reset mid-WAIT: assert wb_rst_i asynchronously -> all outputs 0 in the same cycle; dp_done after release is ignored; next tie grants r0.
